// File: rtl/alu32_pkg.sv
// Shared widths and 4-bit slice arithmetic for the 32-bit CLA add/subtract pipe.
package alu32_pkg;

    localparam int unsigned NIBBLES = 8;
    localparam int unsigned NIB_W   = 4;
    localparam int unsigned DATA_W  = NIBBLES * NIB_W;

    // Group generate/propagate of one nibble, returned as {G, P}.
    // Propagate uses a|b so the same terms drive the external lookahead chip.
    function automatic logic [1:0] gp4(input logic [NIB_W-1:0] a4,
                                       input logic [NIB_W-1:0] b4);
        logic [NIB_W-1:0] p;
        logic [NIB_W-1:0] g;
        logic             gg;
        logic             pp;
        p  = a4 | b4;
        g  = a4 & b4;
        gg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
        pp = &p;
        return {gg, pp};
    endfunction

    // 4-bit ripple add, returned as {sum4, carry into bit 3, carry out}.
    function automatic logic [NIB_W+1:0] ripple4(input logic [NIB_W-1:0] a4,
                                                 input logic [NIB_W-1:0] b4,
                                                 input logic             c);
        logic [NIB_W:0]   cc;
        logic [NIB_W-1:0] s;
        cc    = '0;
        s     = '0;
        cc[0] = c;
        for (int unsigned i = 0; i < NIB_W; i++) begin
            s[i]    = a4[i] ^ b4[i] ^ cc[i];
            cc[i+1] = (a4[i] & b4[i]) | ((a4[i] ^ b4[i]) & cc[i]);
        end
        return {s, cc[NIB_W-1], cc[NIB_W]};
    endfunction

endpackage

// File: rtl/add4_gp.sv
// One 4-bit slice: group G/P for the lookahead and the nibble sum for a given carry in.
module add4_gp
    import alu32_pkg::*;
(
    input  logic             c_in,
    input  logic [NIB_W-1:0] a4,
    input  logic [NIB_W-1:0] b4,
    output logic             g,
    output logic             p,
    output logic [NIB_W-1:0] sum4,
    output logic             c_msb,
    output logic             c_out
);

    logic [1:0]       gp;
    logic [NIB_W+1:0] rip;

    // Lookahead terms and ripple sum are both pure functions of the slice inputs
    always_comb begin
        gp    = gp4(a4, b4);
        rip   = ripple4(a4, b4, c_in);
        g     = gp[1];
        p     = gp[0];
        sum4  = rip[NIB_W+1:2];
        c_msb = rip[1];
        c_out = rip[0];
    end

endmodule

// File: rtl/add32_cla_pipe.sv
// Two-stage 32-bit add/subtract around an external 8-group carry-lookahead chip.
// Stage 1 registers operands and exports nG/nP/Cin; stage 2 folds the chip's
// byte carries into the sum and flags and holds them under valid/ready.
module add32_cla_pipe
    import alu32_pkg::*;
#(
    parameter bit CHECK_CLA = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              op_sub,
    input  logic              cin,
    output logic [NIBBLES-1:0] nP,
    output logic [NIBBLES-1:0] nG,
    output logic              Cin,
    input  logic              Cn_8,
    input  logic              Cn_16,
    input  logic              Cn_24,
    input  logic              Cn_32,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] sum,
    output logic              cout,
    output logic              ovf,
    output logic              zero,
    output logic              cla_err
);

    logic               s1_valid;
    logic [DATA_W-1:0]  a_r;
    logic [DATA_W-1:0]  bs_r;
    logic               cin_r;

    logic               s2_valid;
    logic [DATA_W-1:0]  sum_r;
    logic               cout_r;
    logic               ovf_r;
    logic               zero_r;

    logic               adv2;
    logic               accept;

    logic [NIBBLES-1:0] g_nib;
    logic [NIBBLES-1:0] p_nib;
    logic [NIBBLES-1:0] c_nib;
    logic [NIBBLES-1:0] cmsb_nib;
    logic [NIBBLES-1:0] cout_nib;
    logic [3:0]         cn_byte;
    logic [DATA_W-1:0]  sum_d;
    logic               slice_unused;

    // Handshake: stage 1 may refill in the same cycle it advances
    always_comb begin
        adv2     = s1_valid & (~s2_valid | out_ready);
        in_ready = ~s1_valid | adv2;
        accept   = in_valid & in_ready;
    end

    // Stage 1 operand register; B is inverted for subtract before capture
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            a_r      <= '0;
            bs_r     <= '0;
            cin_r    <= 1'b0;
        end else if (accept) begin
            s1_valid <= 1'b1;
            a_r      <= a;
            bs_r     <= op_sub ? ~b : b;
            cin_r    <= cin;
        end else if (adv2) begin
            s1_valid <= 1'b0;
        end
    end

    // The slices see only stage-1 registers, so G/P to the CLA never loops back
    for (genvar k = 0; k < NIBBLES; k++) begin : g_slice
        add4_gp u_add4_gp (
            .c_in  (c_nib[k]),
            .a4    (a_r[k*NIB_W +: NIB_W]),
            .b4    (bs_r[k*NIB_W +: NIB_W]),
            .g     (g_nib[k]),
            .p     (p_nib[k]),
            .sum4  (sum_d[k*NIB_W +: NIB_W]),
            .c_msb (cmsb_nib[k]),
            .c_out (cout_nib[k])
        );
    end

    // Only the top slice's bit-31 carry feeds a flag; other slice carries are spare
    assign slice_unused = ^{cmsb_nib[NIBBLES-2:0], cout_nib};

    assign nG  = ~g_nib;
    assign nP  = ~p_nib;
    assign Cin = cin_r;

    // Nibble carries: even nibbles take the chip's byte carries, odd nibbles
    // extend one group locally from the preceding even nibble
    always_comb begin
        cn_byte  = {Cn_32, Cn_24, Cn_16, Cn_8};
        c_nib    = '0;
        c_nib[0] = cin_r;
        for (int unsigned k = 1; k < NIBBLES; k++) begin
            if ((k % 2) == 0)
                c_nib[k] = cn_byte[k/2 - 1];
            else
                c_nib[k] = g_nib[k-1] | (p_nib[k-1] & c_nib[k-1]);
        end
    end

    // Stage 2 result register; holds while the consumer stalls
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid <= 1'b0;
            sum_r    <= '0;
            cout_r   <= 1'b0;
            ovf_r    <= 1'b0;
            zero_r   <= 1'b0;
        end else if (adv2) begin
            s2_valid <= 1'b1;
            sum_r    <= sum_d;
            cout_r   <= Cn_32;
            ovf_r    <= cmsb_nib[NIBBLES-1] ^ Cn_32;
            zero_r   <= (sum_d == '0);
        end else if (out_ready) begin
            s2_valid <= 1'b0;
        end
    end

    assign out_valid = s2_valid;
    assign sum       = sum_r;
    assign cout      = cout_r;
    assign ovf       = ovf_r;
    assign zero      = zero_r;

    if (CHECK_CLA) begin : g_chk
        logic [NIBBLES:0] c_la;
        logic [3:0]       cn_exp;
        logic             cla_mismatch;
        logic             cla_err_r;

        // Full lookahead from registered G/P to cross-check the external chip
        always_comb begin
            c_la    = '0;
            c_la[0] = cin_r;
            for (int unsigned k = 0; k < NIBBLES; k++)
                c_la[k+1] = g_nib[k] | (p_nib[k] & c_la[k]);
            cn_exp       = {c_la[8], c_la[6], c_la[4], c_la[2]};
            cla_mismatch = (cn_exp != cn_byte);
        end

        // Sticky error flag, cleared only by reset
        always_ff @(posedge clk) begin
            if (rst)
                cla_err_r <= 1'b0;
            else if (adv2 && cla_mismatch)
                cla_err_r <= 1'b1;
        end

        assign cla_err = cla_err_r;
    end else begin : g_nochk
        assign cla_err = 1'b0;
    end

endmodule

// File: tb/tb_add32_cla_pipe.sv
// Directed bench for add32_cla_pipe with an attached 8-group CLA model,
// a queue-based scoreboard and an independent output monitor.
module tb_add32_cla_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        op_sub;
    logic        cin;
    logic [7:0]  nP;
    logic [7:0]  nG;
    logic        Cin;
    logic        Cn_8;
    logic        Cn_16;
    logic        Cn_24;
    logic        Cn_32;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;
    logic        cla_err;

    logic        fault;
    logic [8:0]  cc;

    logic [34:0] sb[$];
    int          n_vec = 0;
    int          n_bad = 0;
    int          n_acc = 0;
    logic        bp_done;

    logic        held_v;
    logic [34:0] held;

    always #5 clk = ~clk;

    add32_cla_pipe #(.CHECK_CLA(1'b1)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op_sub    (op_sub),
        .cin       (cin),
        .nP        (nP),
        .nG        (nG),
        .Cin       (Cin),
        .Cn_8      (Cn_8),
        .Cn_16     (Cn_16),
        .Cn_24     (Cn_24),
        .Cn_32     (Cn_32),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf),
        .zero      (zero),
        .cla_err   (cla_err)
    );

    // External 8-group lookahead chip; fault pins Cn_16 low
    always_comb begin
        cc    = '0;
        cc[0] = Cin;
        for (int k = 0; k < 8; k++)
            cc[k+1] = ~nG[k] | (~nP[k] & cc[k]);
    end
    assign Cn_8  = cc[2];
    assign Cn_16 = fault ? 1'b0 : cc[4];
    assign Cn_24 = cc[6];
    assign Cn_32 = cc[8];

    task automatic chk(input string name, input logic [34:0] got, input logic [34:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Monitor: pops on every output handshake and checks stability under stall
    always @(negedge clk) begin
        if (rst) begin
            held_v = 1'b0;
        end else begin
            if (held_v && out_valid)
                chk("hold_stable", {sum, cout, ovf, zero}, held);
            if (out_valid && out_ready) begin
                held_v = 1'b0;
                if (sb.size() == 0) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL unexpected_output: got %h expected none", {sum, cout, ovf, zero});
                end else begin
                    chk("result", {sum, cout, ovf, zero}, sb.pop_front());
                end
            end else if (out_valid) begin
                held_v = 1'b1;
                held   = {sum, cout, ovf, zero};
            end else begin
                held_v = 1'b0;
            end
        end
    end

    // Drive one beat and push its expected {sum,cout,ovf,zero} on acceptance
    task automatic send(input logic [31:0] ta, input logic [31:0] tb, input logic ts,
                        input logic tc, input logic [34:0] e);
        a        = ta;
        b        = tb;
        op_sub   = ts;
        cin      = tc;
        in_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready) begin
                sb.push_back(e);
                n_acc++;
                @(posedge clk);
                #1;
                in_valid = 1'b0;
                return;
            end
        end
        in_valid = 1'b0;
        n_vec++;
        n_bad++;
        $display("FAIL accept_timeout: got in_ready=0 expected 1 within 50 cycles");
    endtask

    task automatic drain();
        for (int i = 0; i < 60; i++) begin
            @(posedge clk);
            #1;
            if (sb.size() == 0) return;
        end
        n_vec++;
        n_bad++;
        $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200us");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        op_sub    = 1'b0;
        cin       = 1'b0;
        out_ready = 1'b1;
        fault     = 1'b0;
        bp_done   = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 35'(out_valid), 35'd0);
        chk("rst_in_ready",  35'(in_ready),  35'd1);
        chk("rst_nP",        35'(nP),        35'h0FF);
        chk("rst_nG",        35'(nG),        35'h0FF);
        chk("rst_Cin",       35'(Cin),       35'd0);
        chk("rst_cla_err",   35'(cla_err),   35'd0);
        chk("rst_result",    {sum, cout, ovf, zero}, 35'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // 0xFF + 1: check group G/P while the beat sits in stage 1
        send(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, {32'h0000_0100, 3'b000});
        chk("s1_nG",  35'(nG),  35'h0FE);
        chk("s1_nP",  35'(nP),  35'h0FC);
        chk("s1_Cin", 35'(Cin), 35'd0);
        drain();

        // Streamed vectors: full carry chain, subtract with overflow, equal subtract, cin=0 subtract
        send(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, {32'h0000_0000, 3'b101});
        send(32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1, {32'h7FFF_FFFF, 3'b110});
        send(32'h0000_0005, 32'h0000_0005, 1'b1, 1'b1, {32'h0000_0000, 3'b101});
        send(32'h0000_000A, 32'h0000_0003, 1'b1, 1'b0, {32'h0000_0006, 3'b100});
        drain();

        // Backpressure: four beats with the consumer stalled
        out_ready = 1'b0;
        begin
            int base;
            base = n_acc;
            fork
                begin
                    send(32'h0000_0001, 32'h0000_0002, 1'b0, 1'b0, {32'h0000_0003, 3'b000});
                    send(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, {32'h2345_6789, 3'b000});
                    send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, {32'h8000_0000, 3'b010});
                    send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, {32'hFFFF_FFFE, 3'b100});
                    bp_done = 1'b1;
                end
            join_none
            for (int i = 0; i < 20; i++) begin
                @(posedge clk);
                #2;
                if (n_acc >= base + 2) break;
            end
            chk("bp_accepts",   35'(n_acc - base), 35'd2);
            chk("bp_in_ready",  35'(in_ready),  35'd0);
            chk("bp_out_valid", 35'(out_valid), 35'd1);
            repeat (3) @(posedge clk);
            #1;
            chk("bp_in_ready_held", 35'(in_ready), 35'd0);
            out_ready = 1'b1;
            for (int i = 0; i < 60; i++) begin
                @(posedge clk);
                #1;
                if (bp_done && sb.size() == 0) break;
            end
            chk("bp_drained", {33'(sb.size()), 1'b0, bp_done}, 35'd1);
        end

        // CLA fault: Cn_16 stuck low on a carry that must cross bit 16
        fault = 1'b1;
        send(32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0, {32'h0000_0000, 3'b001});
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (cla_err) break;
        end
        chk("cla_err_set", 35'(cla_err), 35'd1);
        fault = 1'b0;
        drain();
        repeat (3) @(posedge clk);
        #1;
        chk("cla_err_sticky", 35'(cla_err), 35'd1);

        // Reset with a beat in flight discards it and clears the error
        out_ready = 1'b0;
        send(32'h0000_0003, 32'h0000_0004, 1'b0, 1'b0, {32'h0000_0007, 3'b000});
        @(posedge clk);
        #1;
        rst = 1'b1;
        sb.delete();
        @(negedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_cla_err",   35'(cla_err),   35'd0);
        chk("mid_rst_out_valid", 35'(out_valid), 35'd0);
        chk("mid_rst_nP",        35'(nP),        35'h0FF);
        @(posedge clk);
        #1;
        out_ready = 1'b1;

        // Clean operation after reset
        send(32'h1234_5678, 32'h0000_0678, 1'b1, 1'b1, {32'h1234_5000, 3'b100});
        drain();
        chk("final_cla_err", 35'(cla_err), 35'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/add32_cla_pipe.md
Name: add32_cla_pipe

Overview:
- 32-bit two-stage pipelined add/subtract unit built as eight 4-bit slices.
- Stage 1 registers the operands and drives active-low group generate/propagate (nG/nP) for an external 8-group carry-lookahead chip.
- Stage 2 consumes that chip's carries (Cn_8/16/24/32) to form the sum and flags, then holds the result under a valid/ready handshake.
- It sits directly upstream and downstream of the CLA in the ALU datapath.

Parameters:
- CHECK_CLA, 1, when 1 stage 2 recomputes the byte carries internally from registered G/P and raises cla_err on any mismatch.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  unit can accept a beat this cycle.
- a  in  32  operand A.
- b  in  32  operand B.
- op_sub  in  1  0 = A+B+cin; 1 = A+~B+cin.
- cin  in  1  carry in; for subtract the caller drives 1 to get A-B.
- nP  out  8  group propagate to CLA, active low, from stage-1 registers.
- nG  out  8  group generate to CLA, active low, from stage-1 registers.
- Cin  out  1  registered carry in to CLA, active high.
- Cn_8, Cn_16, Cn_24, Cn_32  in  1 each  carries from CLA, active high, combinational function of nP/nG/Cin.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- sum  out  32  result.
- cout  out  1  carry out (= Cn_32).
- ovf  out  1  signed overflow.
- zero  out  1  sum == 0.
- cla_err  out  1  sticky CLA mismatch flag.

Behaviour:
- Reset (rst=1 at a clk edge): s1_valid, s2_valid, out_valid, cla_err = 0. sum, cout, ovf, zero = 0. Stage-1 data = 0, so nP=8'hFF, nG=8'hFF, Cin=0. rst overrides any handshake in the same cycle; in-flight beats are discarded.
- Stage 1 (bs = op_sub ? ~b : b):
  - Registers a, bs, cin.
  - Per nibble k (bits 4k+3..4k): p_i=a_i|bs_i, g_i=a_i&bs_i.
  - G_k = g3 | p3g2 | p3p2g1 | p3p2p1g0; P_k = p3&p2&p1&p0.
  - nG[k]=~G_k, nP[k]=~P_k, both combinational from stage-1 registers only. No path from a/b/cin to nP/nG/Cin, so no combinational loop through the CLA.
- Stage 2 register captures:
  - Nibble carries: c0=Cin, c1=G0|P0&c0, c2=Cn_8, c3=G2|P2&c2, c4=Cn_16, c5=G4|P4&c4, c6=Cn_24, c7=G6|P6&c6.
  - Each nibble sum is a 4-bit ripple of a^bs with its carry.
  - cout=Cn_32; ovf = carry into bit 31 XOR cout; zero = (sum==0).
- Handshake and pipelining:
  - adv2 = s1_valid & (!s2_valid | out_ready).
  - in_ready = !s1_valid | adv2.
  - Beat accepted when in_valid & in_ready.
  - out_valid = s2_valid; output holds stable while out_valid & !out_ready.
  - Latency 2 cycles from accept to out_valid. Throughput 1/cycle with out_ready held high.
  - Simultaneous accept and adv2: stage 1 reloads in the same cycle. No bubble, no loss, no duplication.
- Full pipeline (both stages valid, out_ready=0): in_ready=0; nP/nG stay constant.
- CHECK_CLA=1: on adv2, compare Cn_8/16/24/32 against the internally computed lookahead. Any mismatch sets cla_err, which stays set until rst. CHECK_CLA=0: cla_err tied 0.
- Wrap-around: the sum is modulo 2^32; cout and ovf report the wrap.

Decomposition:
- alu32_pkg holds:
  - NIBBLES=8 and NIB_W=4.
  - Function gp4(a4,b4) returning {G,P}.
  - Function ripple4(a4,b4,c) returning {sum4,cmsb,cout}.
- Sub-module add4_gp: one 4-bit slice producing G, P, and sum given a carry in. Instantiated 8 times in stage 2; its G/P outputs are reused in stage 1.

Test Plan:
- Reset: hold rst 2 cycles -> out_valid=0, in_ready=1, nP=nG=8'hFF, cla_err=0.
- Add: a=32'h0000_00FF, b=1, op_sub=0, cin=0, CLA model attached -> after 2 cycles sum=32'h0000_0100, cout=0, ovf=0, zero=0. Also check nG[0]=0 and nP[1]=0 while in stage 1.
- Full carry chain: a=32'hFFFF_FFFF, b=1, cin=0 -> sum=0, cout=1, zero=1, ovf=0.
- Subtract and overflow: a=32'h8000_0000, b=1, op_sub=1, cin=1 -> sum=32'h7FFF_FFFF, cout=1, ovf=1. Then a=5, b=5 subtract -> sum=0, zero=1, cout=1.
- Backpressure: stream 4 beats with out_ready=0 for 3 cycles -> in_ready drops after 2 accepts, output held stable. Release -> all 4 results in order, none lost or duplicated.
- CLA fault: force Cn_16=0 on a=32'h0000_FFFF, b=1 -> cla_err=1 and stays sticky. Then rst=1 mid-stream -> cla_err=0, out_valid=0 the next cycle.
